// File: rtl/fp_addsub_scheduler.sv
// Two-requester scheduler for a shared fixed-latency FP add/sub unit.
// Round-robin issue and per-op tag tracking through the unit's latency.
// Results are steered into per-requester response FIFOs.
// Credits (inflight + queued < RSP_DEPTH) guarantee that every returning result has a slot.
module fp_addsub_scheduler #(
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic        i_req0_mode,
    input  logic [1:0]  i_req0_op,
    input  logic [63:0] i_req0_a,
    input  logic [63:0] i_req0_b,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic        i_req1_mode,
    input  logic [1:0]  i_req1_op,
    input  logic [63:0] i_req1_a,
    input  logic [63:0] i_req1_b,
    output logic        o_unit_valid,
    output logic        o_unit_mode,
    output logic [1:0]  o_unit_op,
    output logic [63:0] o_unit_a,
    output logic [63:0] o_unit_b,
    input  logic [63:0] i_unit_res,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic [63:0] o_rsp0_data,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [63:0] o_rsp1_data,
    output logic        o_busy
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [1:0]  req_valid;
    logic [1:0]  req_mode;
    logic [1:0]  rsp_ready;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic [1:0]  rsp_valid;
    logic [1:0]  req_op   [2];
    logic [63:0] req_a    [2];
    logic [63:0] req_b    [2];
    logic [63:0] rsp_data [2];
    logic        gsel;

    logic        last_reg;
    logic        unit_valid_reg;
    logic        unit_mode_reg;
    logic        unit_tag_reg;
    logic [1:0]  unit_op_reg;
    logic [63:0] unit_a_reg;
    logic [63:0] unit_b_reg;

    logic [LAT-1:0] trk_valid_reg;
    logic [LAT-1:0] trk_tag_reg;
    logic           ret_valid;
    logic           ret_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requester ports gathered into arrays so per-requester logic can be generated
    assign req_valid = {i_req1_valid, i_req0_valid};
    assign req_mode  = {i_req1_mode, i_req0_mode};
    assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};
    assign req_op[0] = i_req0_op;
    assign req_op[1] = i_req1_op;
    assign req_a[0]  = i_req0_a;
    assign req_a[1]  = i_req1_a;
    assign req_b[0]  = i_req0_b;
    assign req_b[1]  = i_req1_b;

    // Round-robin grant: a lone eligible requester wins, a tie goes to the one not served last
    always_comb begin
        grant = elig;
        if (&elig) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    assign gsel = grant[1];

    // Issue register: captures the granted payload; payload holds when nothing is granted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_reg       <= 1'b1;
            unit_valid_reg <= 1'b0;
            unit_mode_reg  <= 1'b0;
            unit_tag_reg   <= 1'b0;
            unit_op_reg    <= 2'd0;
            unit_a_reg     <= 64'd0;
            unit_b_reg     <= 64'd0;
        end else begin
            unit_valid_reg <= |grant;
            if (|grant) begin
                unit_mode_reg <= req_mode[gsel];
                unit_op_reg   <= req_op[gsel];
                unit_a_reg    <= req_a[gsel];
                unit_b_reg    <= req_b[gsel];
                unit_tag_reg  <= gsel;
                last_reg      <= gsel;
            end
        end
    end

    // Tag pipeline fed by the issue register; its last stage lines up with i_unit_res
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trk_valid_reg <= '0;
            trk_tag_reg   <= '0;
        end else begin
            trk_valid_reg[0] <= unit_valid_reg;
            trk_tag_reg[0]   <= unit_tag_reg;
            for (int j = 1; j < LAT; j++) begin
                trk_valid_reg[j] <= trk_valid_reg[j-1];
                trk_tag_reg[j]   <= trk_tag_reg[j-1];
            end
        end
    end

    assign ret_valid = trk_valid_reg[LAT-1];
    assign ret_tag   = trk_tag_reg[LAT-1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [2:0]    inflight_reg;
            logic [2:0]    fifo_cnt_reg;
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [63:0]   mem [RSP_DEPTH];
            logic          wr;
            logic          pop;
            logic          iss;

            assign wr  = ret_valid && (ret_tag == 1'(gi));
            assign pop = rsp_valid[gi] && rsp_ready[gi];
            assign iss = grant[gi];

            assign elig[gi]      = req_valid[gi] &&
                                   ((4'(inflight_reg) + 4'(fifo_cnt_reg)) < 4'(RSP_DEPTH));
            assign rsp_valid[gi] = (fifo_cnt_reg != 3'd0);
            assign rsp_data[gi]  = rsp_valid[gi] ? mem[rd_ptr_reg] : 64'd0;

            // Credit counters and FIFO pointers; simultaneous inc/dec cancel out
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    inflight_reg <= 3'd0;
                    fifo_cnt_reg <= 3'd0;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                end else begin
                    if (iss && !wr) begin
                        inflight_reg <= inflight_reg + 3'd1;
                    end else if (wr && !iss) begin
                        inflight_reg <= inflight_reg - 3'd1;
                    end
                    if (wr && !pop) begin
                        fifo_cnt_reg <= fifo_cnt_reg + 3'd1;
                    end else if (pop && !wr) begin
                        fifo_cnt_reg <= fifo_cnt_reg - 3'd1;
                    end
                    if (wr) begin
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                        assert (fifo_cnt_reg != 3'(RSP_DEPTH));
                    end
                    if (pop) begin
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    end
                end
            end

            // Response storage, written straight from the unit result bus
            always_ff @(posedge i_clk) begin
                if (wr) begin
                    mem[wr_ptr_reg] <= i_unit_res;
                end
            end
        end
    endgenerate

    assign o_req0_ready = grant[0];
    assign o_req1_ready = grant[1];
    assign o_unit_valid = unit_valid_reg;
    assign o_unit_mode  = unit_mode_reg;
    assign o_unit_op    = unit_op_reg;
    assign o_unit_a     = unit_a_reg;
    assign o_unit_b     = unit_b_reg;
    assign o_rsp0_valid = rsp_valid[0];
    assign o_rsp0_data  = rsp_data[0];
    assign o_rsp1_valid = rsp_valid[1];
    assign o_rsp1_data  = rsp_data[1];
    assign o_busy       = unit_valid_reg | (|trk_valid_reg) | (|rsp_valid);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Scoreboard bench for fp_addsub_scheduler: a behavioural FP unit model returns results
// after LAT cycles; a monitor checks grants, issue payloads, busy and response data.
module tb_fp_addsub_scheduler;

    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        mode;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        r0 = 1'b1, r1 = 1'b1;
    pl_t         pl0 = '0, pl1 = '0;
    logic [63:0] unit_res;
    logic        o_req0_ready, o_req1_ready, o_unit_valid, o_unit_mode;
    logic [1:0]  o_unit_op;
    logic [63:0] o_unit_a, o_unit_b, o_rsp0_data, o_rsp1_data;
    logic        o_rsp0_valid, o_rsp1_valid, o_busy;

    int tests = 0;
    int fails = 0;

    fp_addsub_scheduler #(.LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .o_req0_ready(o_req0_ready), .i_req0_mode(pl0.mode),
        .i_req0_op(pl0.op), .i_req0_a(pl0.a), .i_req0_b(pl0.b),
        .i_req1_valid(v1), .o_req1_ready(o_req1_ready), .i_req1_mode(pl1.mode),
        .i_req1_op(pl1.op), .i_req1_a(pl1.a), .i_req1_b(pl1.b),
        .o_unit_valid(o_unit_valid), .o_unit_mode(o_unit_mode), .o_unit_op(o_unit_op),
        .o_unit_a(o_unit_a), .o_unit_b(o_unit_b), .i_unit_res(unit_res),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(r0), .o_rsp0_data(o_rsp0_data),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(r1), .o_rsp1_data(o_rsp1_data),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // ---------------- FP unit behaviour ----------------
    function automatic real sp2real(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'h00 || s[30:23] == 8'hFF) return 0.0;
        e = 11'(s[30:23]) + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(input logic [63:0] d);
        logic [10:0] de;
        de = d[62:52];
        if (de < 11'd897 || de > 11'd1150) return {d[63], 31'd0};
        return {d[63], 8'(de - 11'd896), d[51:29]};
    endfunction

    function automatic logic [63:0] unit_fn(input pl_t p);
        real x, y, r;
        logic [63:0] d;
        if (p.mode) begin
            x = $bitstoreal(p.a);
            y = $bitstoreal(p.b);
        end else begin
            x = sp2real(p.a[31:0]);
            y = sp2real(p.b[31:0]);
        end
        r = (p.op == 2'b10) ? x - y : x + y;
        d = $realtobits(r);
        return p.mode ? d : {32'd0, real2sp(d)};
    endfunction

    // Unit model: result appears exactly LAT cycles after o_unit_valid; junk otherwise
    logic [63:0] pipe [LAT];
    assign unit_res = pipe[LAT-1];
    always @(posedge clk) begin
        pipe[0] <= o_unit_valid ? unit_fn({o_unit_mode, o_unit_op, o_unit_a, o_unit_b})
                                : {$urandom, $urandom};
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end

    task automatic check(input string name, input logic [130:0] act, input logic [130:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    logic [63:0] exp_q0[$], exp_q1[$];
    int   out_cnt0 = 0, out_cnt1 = 0;
    int   acc_cnt0 = 0, acc_cnt1 = 0;
    logic acc0 = 1'b0, acc1 = 1'b0;
    logic last_m = 1'b1;
    logic exp_uv = 1'b0;
    pl_t  exp_pl = '0;

    initial begin
        logic e0, e1, g0, g1;
        logic [63:0] ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_cnt0 = 0; out_cnt1 = 0;
                exp_q0.delete(); exp_q1.delete();
                last_m = 1'b1; exp_uv = 1'b0;
            end else begin
                e0 = v0 && (out_cnt0 < DEPTH);
                e1 = v1 && (out_cnt1 < DEPTH);
                g0 = e0 && (!e1 || last_m);
                g1 = e1 && (!e0 || !last_m);
                check("req0_ready", 131'(o_req0_ready), 131'(g0));
                check("req1_ready", 131'(o_req1_ready), 131'(g1));
                check("unit_valid", 131'(o_unit_valid), 131'(exp_uv));
                if (exp_uv)
                    check("unit_payload", {o_unit_mode, o_unit_op, o_unit_a, o_unit_b}, exp_pl);
                check("busy", 131'(o_busy), 131'((out_cnt0 + out_cnt1) != 0));
                if (o_rsp0_valid && exp_q0.size() == 0) begin
                    check("rsp0_spurious", 131'(o_rsp0_valid), 131'(0));
                end else if (o_rsp0_valid && r0) begin
                    ev = exp_q0.pop_front();
                    check("rsp0_data", 131'(o_rsp0_data), 131'(ev));
                    $display("[TB] %0t rsp0 data %h", $time, o_rsp0_data);
                    out_cnt0--;
                end
                if (o_rsp1_valid && exp_q1.size() == 0) begin
                    check("rsp1_spurious", 131'(o_rsp1_valid), 131'(0));
                end else if (o_rsp1_valid && r1) begin
                    ev = exp_q1.pop_front();
                    check("rsp1_data", 131'(o_rsp1_data), 131'(ev));
                    $display("[TB] %0t rsp1 data %h", $time, o_rsp1_data);
                    out_cnt1--;
                end
                exp_uv = g0 | g1;
                if (g0) begin
                    exp_pl = pl0; exp_q0.push_back(unit_fn(pl0));
                    out_cnt0++; acc_cnt0++; acc0 = 1'b1; last_m = 1'b0;
                end
                if (g1) begin
                    exp_pl = pl1; exp_q1.push_back(unit_fn(pl1));
                    out_cnt1++; acc_cnt1++; acc1 = 1'b1; last_m = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic auto_gen = 1'b1;

    function automatic pl_t rand_pl();
        pl_t p;
        p.mode = 1'($urandom);
        p.op   = 2'($urandom);
        p.a    = {$urandom, $urandom};
        p.b    = {$urandom, $urandom};
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) begin acc0 = 1'b0; if (auto_gen) pl0 = rand_pl(); end
        if (acc1) begin acc1 = 1'b0; if (auto_gen) pl1 = rand_pl(); end
    endtask

    task automatic drain();
        int n;
        v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
        n = 0;
        while (o_busy && n < 100) begin step(); n++; end
        check("drain_timeout", 131'(o_busy), 131'(0));
    endtask

    initial begin
        int base;
        pl0 = rand_pl(); pl1 = rand_pl();
        repeat (3) step();
        rst_n = 1'b1;

        // Reset with ops in flight; stale results must be ignored afterwards
        v0 = 1'b1; v1 = 1'b1;
        repeat (3) step();
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check("reset_outputs",
              131'({o_req0_ready, o_req1_ready, o_unit_valid, o_unit_mode, o_unit_op,
                    o_rsp0_valid, o_rsp1_valid, o_busy}), 131'(0));
        check("reset_unit_a", 131'(o_unit_a), 131'(0));
        check("reset_unit_b", 131'(o_unit_b), 131'(0));
        check("reset_rsp_data", 131'({o_rsp0_data, o_rsp1_data}), 131'(0));
        repeat (8) begin
            step();
            check("stale_rsp_valid", 131'({o_rsp0_valid, o_rsp1_valid}), 131'(0));
        end

        // Single request: 1.0 + 2.0 single precision, response 5 cycles after accept
        auto_gen = 1'b0;
        pl0 = '{mode: 1'b0, op: 2'b01, a: 64'h3F800000, b: 64'h40000000};
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        @(negedge clk);
        check("single_unit_valid", 131'(o_unit_valid), 131'(1));
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("single_rsp0_valid", 131'(o_rsp0_valid), 131'(c == 5));
            if (c == 5) check("single_rsp0_data", 131'(o_rsp0_data), 131'(64'h40400000));
        end
        auto_gen = 1'b1;
        drain();

        // Round-robin: both requesters valid, responses drained every cycle
        v0 = 1'b1; v1 = 1'b1;
        repeat (12) step();
        drain();

        // Credit stall: no draining of rsp0 -> exactly DEPTH accepts
        r0 = 1'b0; v0 = 1'b1;
        base = acc_cnt0;
        repeat (12) step();
        check("stall_accepts", 131'(acc_cnt0 - base), 131'(DEPTH));
        @(negedge clk);
        check("stall_ready_low", 131'(o_req0_ready), 131'(0));
        step();
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        base = acc_cnt0;
        repeat (10) step();
        check("one_pop_one_accept", 131'(acc_cnt0 - base), 131'(1));
        drain();

        // Randomized traffic with random backpressure (covers simultaneous events and wrap)
        repeat (400) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();
        check("queues_empty", 131'(exp_q0.size() + exp_q1.size()), 131'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
